alu_vec_aux: RTL and testbench



---
 rtl/alu_vec_aux.sv | 93 +++++++++
 tb/tb_alu_vec_aux.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alu_vec_aux.sv
// One lane of the SIMD vector ALU: MUL/SUB/ADD/IDX/SET on signed WIDTH-bit
// operands, producing a registered result and {V,N,Z,C} flags one cycle later.
module alu_vec_aux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [2:0]       opcode,
  input  logic             flag_scalar,
  input  logic [31:0]      instance_num,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  typedef enum logic [2:0] {
    OP_MUL = 3'b000,
    OP_SUB = 3'b001,
    OP_ADD = 3'b010,
    OP_IDX = 3'b011,
    OP_SET = 3'b111
  } opcode_e;

  logic [WIDTH-1:0]          opB;
  logic [WIDTH:0]            sumExt;
  logic [WIDTH-1:0]          diff;
  logic signed [2*WIDTH-1:0] prodFull;
  logic [WIDTH-1:0]          idxVal;

  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flags_d, flags_q;
  logic             validOp;
  logic             ovf;
  logic             carry;

  assign opB    = flag_scalar ? data_c : data_b;
  assign sumExt = {1'b0, data_a} + {1'b0, opB};
  assign diff   = data_a - opB;
  assign idxVal = WIDTH'(instance_num);

  // Operands are sign-extended to the full product width so the multiply is
  // exact and the overflow check can compare against the truncated result.
  assign prodFull = $signed({{WIDTH{data_a[WIDTH-1]}}, data_a})
                  * $signed({{WIDTH{opB[WIDTH-1]}}, opB});

  always_comb begin
    result_d = '0;
    validOp  = 1'b1;
    ovf      = 1'b0;
    carry    = 1'b0;
    case (opcode)
      OP_MUL: begin
        result_d = prodFull[WIDTH-1:0];
        ovf      = (prodFull != $signed({{WIDTH{prodFull[WIDTH-1]}}, prodFull[WIDTH-1:0]}));
      end
      OP_SUB: begin
        result_d = diff;
        ovf      = (data_a[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_ADD: begin
        result_d = sumExt[WIDTH-1:0];
        ovf      = (data_a[WIDTH-1] == opB[WIDTH-1]) && (sumExt[WIDTH-1] != data_a[WIDTH-1]);
        carry    = sumExt[WIDTH];
      end
      OP_IDX:  result_d = idxVal;
      OP_SET:  result_d = data_c;
      default: validOp  = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = '0;
    if (validOp) begin
      flags_d = {ovf, result_d[WIDTH-1], (result_d == '0), carry};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_vec_aux.sv
// Directed self-checking bench for alu_vec_aux (WIDTH=8) with hand-computed
// results and {V,N,Z,C} flags.
module tb_alu_vec_aux;

  logic        clk;
  logic        rstN;
  logic [7:0]  dataA;
  logic [7:0]  dataB;
  logic [7:0]  dataC;
  logic [2:0]  opcode;
  logic        flagScalar;
  logic [31:0] instanceNum;
  logic [7:0]  result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  alu_vec_aux #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .data_a       (dataA),
    .data_b       (dataB),
    .data_c       (dataC),
    .opcode       (opcode),
    .flag_scalar  (flagScalar),
    .instance_num (instanceNum),
    .result       (result),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, let one rising edge capture, sample 1 ns later.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [2:0] op,
                               input logic fs, input logic [31:0] inst,
                               input logic rn);
    @(negedge clk);
    dataA       = a;
    dataB       = b;
    dataC       = c;
    opcode      = op;
    flagScalar  = fs;
    instanceNum = inst;
    rstN        = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expR,
                             input logic [3:0] expF);
    checks++;
    assert (result === expR) else begin
      errors++;
      $error("[TB] FAIL %s result: got %0d expected %0d", tag, $signed(result), $signed(expR));
    end
    checks++;
    assert (flags === expF) else begin
      errors++;
      $error("[TB] FAIL %s flags: got %b expected %b", tag, flags, expF);
    end
  endtask

  initial begin
    rstN = 1'b0; dataA = '0; dataB = '0; dataC = '0;
    opcode = 3'b000; flagScalar = 1'b0; instanceNum = '0;

    applyStimulus(8'sd50, 8'sd25, 8'sd0, 3'b010, 1'b0, 32'd0, 1'b0);
    checkOutput("reset", 8'd0, 4'b0000);

    applyStimulus(8'sd50, 8'sd25, 8'sd0, 3'b010, 1'b0, 32'd0, 1'b1);
    checkOutput("add", 8'sd75, 4'b0000);
    applyStimulus(8'sd100, 8'sd50, 8'sd0, 3'b010, 1'b0, 32'd0, 1'b1);
    checkOutput("add_ovf", -8'sd106, 4'b1100);
    applyStimulus(-8'sd1, -8'sd1, 8'sd0, 3'b010, 1'b0, 32'd0, 1'b1);
    checkOutput("add_carry", -8'sd2, 4'b0101);

    applyStimulus(8'sd50, 8'sd25, 8'sd0, 3'b001, 1'b0, 32'd0, 1'b1);
    checkOutput("sub", 8'sd25, 4'b0000);
    applyStimulus(8'sd25, 8'sd50, 8'sd0, 3'b001, 1'b0, 32'd0, 1'b1);
    checkOutput("sub_neg", -8'sd25, 4'b0100);
    applyStimulus(-8'sd128, 8'sd1, 8'sd0, 3'b001, 1'b0, 32'd0, 1'b1);
    checkOutput("sub_ovf", 8'sd127, 4'b1000);

    applyStimulus(8'sd10, 8'sd12, 8'sd0, 3'b000, 1'b0, 32'd0, 1'b1);
    checkOutput("mul", 8'sd120, 4'b0000);
    applyStimulus(8'sd50, 8'sd3, 8'sd0, 3'b000, 1'b0, 32'd0, 1'b1);
    checkOutput("mul_ovf", -8'sd106, 4'b1100);
    applyStimulus(-8'sd20, 8'sd3, 8'sd0, 3'b000, 1'b0, 32'd0, 1'b1);
    checkOutput("mul_neg", -8'sd60, 4'b0100);

    applyStimulus(8'sd9, 8'sd9, 8'sd42, 3'b111, 1'b1, 32'd0, 1'b1);
    checkOutput("set", 8'sd42, 4'b0000);
    applyStimulus(8'sd0, 8'sd0, -8'sd50, 3'b111, 1'b0, 32'd0, 1'b1);
    checkOutput("set_neg", -8'sd50, 4'b0100);
    applyStimulus(8'sd1, 8'sd2, 8'sd3, 3'b011, 1'b0, 32'd5, 1'b1);
    checkOutput("idx", 8'sd5, 4'b0000);
    applyStimulus(8'sd0, 8'sd0, 8'sd0, 3'b011, 1'b0, 32'h0000_01FF, 1'b1);
    checkOutput("idx_trunc", 8'hFF, 4'b0100);

    applyStimulus(8'sd7, 8'sd99, 8'sd3, 3'b010, 1'b1, 32'd0, 1'b1);
    checkOutput("scalar_add", 8'sd10, 4'b0000);
    applyStimulus(8'sd7, 8'sd99, 8'sd3, 3'b001, 1'b1, 32'd0, 1'b1);
    checkOutput("scalar_sub", 8'sd4, 4'b0000);
    applyStimulus(8'sd7, 8'sd99, 8'sd3, 3'b000, 1'b1, 32'd0, 1'b1);
    checkOutput("scalar_mul", 8'sd21, 4'b0000);

    applyStimulus(8'sd50, 8'sd25, 8'sd1, 3'b100, 1'b0, 32'd7, 1'b1);
    checkOutput("rsvd100", 8'd0, 4'b0000);
    applyStimulus(-8'sd1, -8'sd1, 8'sd1, 3'b110, 1'b0, 32'd7, 1'b1);
    checkOutput("rsvd110", 8'd0, 4'b0000);

    applyStimulus(8'sd100, 8'sd50, 8'sd0, 3'b010, 1'b0, 32'd0, 1'b1);
    checkOutput("pre_reset", -8'sd106, 4'b1100);
    applyStimulus(8'sd100, 8'sd50, 8'sd0, 3'b010, 1'b0, 32'd0, 1'b0);
    checkOutput("mid_reset", 8'd0, 4'b0000);

    applyStimulus(8'sd5, 8'sd5, 8'sd0, 3'b001, 1'b0, 32'd0, 1'b1);
    checkOutput("sub_zero", 8'd0, 4'b0010);
    applyStimulus(-8'sd1, 8'sd1, 8'sd0, 3'b010, 1'b0, 32'd0, 1'b1);
    checkOutput("add_zero", 8'd0, 4'b0011);

    // Result must hold steady across the low half of the cycle.
    @(negedge clk);
    checkOutput("hold", 8'd0, 4'b0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
